// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t   : FSM state encoding (IDLE, RUN, DONE), 2 bits
//   cnt_width : step-counter width for a given number of steps (minimum 1)
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // $clog2(1) is 0, so a single-step configuration still needs one counter bit.
   function automatic int cnt_width(input int n_steps);
      return (n_steps <= 1) ? 1 : $clog2(n_steps);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operation request / result bundle for serial_adder.
//   master : drives start, sub, Ai, Bi, Ci; observes busy, done, So, Co, ovf
//   slave  : the adder side of the same signals
// WIDTH must match the WIDTH parameter of the serial_adder it connects to.
interface serial_adder_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] Ai;
   logic [WIDTH-1:0] Bi;
   logic             Ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] So;
   logic             Co;
   logic             ovf;

   modport master (
      output start, sub, Ai, Bi, Ci,
      input  busy, done, So, Co, ovf
   );

   modport slave (
      input  start, sub, Ai, Bi, Ci,
      output busy, done, So, Co, ovf
   );

endinterface

// File: rtl/serial_adder_fa_slice.sv
// Combinational STEP-bit ripple-carry adder slice.
//   a, b    : STEP-bit addends
//   cin     : carry into bit 0
//   s       : STEP-bit sum
//   cout    : carry out of bit STEP-1
//   msb_cin : carry into bit STEP-1 (with cout gives signed overflow)
module fa_slice #(
   parameter int STEP = 1
) (
   input  logic [STEP-1:0] a,
   input  logic [STEP-1:0] b,
   input  logic            cin,
   output logic [STEP-1:0] s,
   output logic            cout,
   output logic            msb_cin
);

   // A scalar running carry keeps the ripple inside one process, so no
   // self-referencing carry vector is needed.
   always_comb begin
      logic c;
      c       = cin;
      msb_cin = cin;
      s       = '0;
      for (int i = 0; i < STEP; i++) begin
         msb_cin = c;
         s[i]    = a[i] ^ b[i] ^ c;
         c       = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes STEP bits per clock through one
// fa_slice and a registered carry, WIDTH/STEP RUN cycles per operation.
//   clk, rst_n : clock (rising edge) and synchronous active-low reset
//   bus.start  : request, taken only in IDLE and not during the done pulse
//   bus.sub    : 0 = Ai + Bi + Ci, 1 = Ai - Bi (Ci ignored)
//   bus.Ai/Bi/Ci : operands, captured on an accepted start
//   bus.busy   : operation in progress (RUN)
//   bus.done   : one-cycle pulse, So/Co/ovf valid from this cycle on
//   bus.So/Co/ovf : result, carry-out (1 = no borrow on sub), signed overflow
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int NSTEPS = WIDTH / STEP;
   localparam int CNT_W  = cnt_width(NSTEPS);

   if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_chk
      $error("serial_adder: WIDTH must be >= 2 and a multiple of STEP");
   end

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic             ovf_acc;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] so_q;
   logic             co_q;
   logic             ovf_q;

   logic [STEP-1:0]  sl_s;
   logic             sl_cout;
   logic             sl_msb_cin;
   logic [WIDTH-1:0] res_next;

   fa_slice #(.STEP(STEP)) u_slice (
      .a       (a_sr[STEP-1:0]),
      .b       (b_sr[STEP-1:0]),
      .cin     (carry),
      .s       (sl_s),
      .cout    (sl_cout),
      .msb_cin (sl_msb_cin)
   );

   // New slice bits enter at the top; after NSTEPS shifts the first slice
   // result has reached bit 0. Written as shift/or so STEP == WIDTH needs no
   // special case.
   assign res_next = (WIDTH'(sl_s) << (WIDTH - STEP)) | (res_sr >> STEP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         carry   <= 1'b0;
         ovf_acc <= 1'b0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         so_q    <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               // done_q high means DONE has just handed back to IDLE; a start
               // in that cycle is refused.
               if (bus.start && !done_q) begin
                  a_sr   <= bus.Ai;
                  b_sr   <= bus.Bi ^ {WIDTH{bus.sub}};
                  carry  <= bus.sub ? 1'b1 : bus.Ci;
                  cnt    <= '0;
                  res_sr <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> STEP;
               b_sr    <= b_sr >> STEP;
               res_sr  <= res_next;
               carry   <= sl_cout;
               // Overwritten every step; the last (MSB) slice value survives.
               ovf_acc <= sl_msb_cin ^ sl_cout;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(NSTEPS - 1)) begin
                  busy_q <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               so_q   <= res_sr;
               co_q   <= carry;
               ovf_q  <= ovf_acc;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.So   = so_q;
   assign bus.Co   = co_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/STEP=1 and a 16-bit/STEP=4
// instance sharing clock and reset.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8))  bus8 ();
   serial_adder_if #(.WIDTH(16)) bus16 ();

   serial_adder #(.WIDTH(8), .STEP(1)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   serial_adder #(.WIDTH(16), .STEP(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit w16, input logic st, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb);
      if (w16) begin
         bus16.start = st; bus16.Ai = a; bus16.Bi = b; bus16.Ci = ci; bus16.sub = sb;
      end else begin
         bus8.start = st; bus8.Ai = a[7:0]; bus8.Bi = b[7:0]; bus8.Ci = ci; bus8.sub = sb;
      end
   endtask

   task automatic sample(input bit w16, output logic bz, output logic dn, output logic [15:0] so,
                         output logic co, output logic ov);
      if (w16) begin
         bz = bus16.busy; dn = bus16.done; so = bus16.So; co = bus16.Co; ov = bus16.ovf;
      end else begin
         bz = bus8.busy; dn = bus8.done; so = {8'h00, bus8.So}; co = bus8.Co; ov = bus8.ovf;
      end
   endtask

   // One operation: latency, busy length, result, single done pulse, refusal
   // of a start in the done cycle, result hold. inj re-pulses start with other
   // operands during RUN.
   task automatic do_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input bit inj,
                        input logic [15:0] eso, input logic eco, input logic eovf, input string tag);
      int lat, nbusy, done_k;
      logic bz, dn, co, ov;
      logic [15:0] so;
      lat = w16 ? 5 : 9;
      @(negedge clk);
      drive(w16, 1'b1, a, b, ci, sb);
      @(posedge clk); #1;
      drive(w16, 1'b0, a, b, ci, sb);
      sample(w16, bz, dn, so, co, ov);
      nbusy  = int'(bz);
      done_k = 0;
      for (int k = 1; k <= 30 && done_k == 0; k++) begin
         if (inj && k == 3) begin
            @(negedge clk);
            drive(w16, 1'b1, ~a, ~b, ~ci, ~sb);
         end
         @(posedge clk); #1;
         drive(w16, 1'b0, a, b, ci, sb);
         sample(w16, bz, dn, so, co, ov);
         if (dn) done_k = k;
         else nbusy += int'(bz);
      end
      chk({tag, " latency"}, done_k, lat);
      chk({tag, " busy_cycles"}, nbusy, w16 ? 4 : 8);
      chk({tag, " So"}, 32'(so), 32'(eso));
      chk({tag, " Co"}, 32'(co), 32'(eco));
      chk({tag, " ovf"}, 32'(ov), 32'(eovf));
      // start during the done cycle must be refused
      @(negedge clk);
      drive(w16, 1'b1, 16'h5A5A, 16'hA5A5, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(w16, 1'b0, a, b, ci, sb);
      sample(w16, bz, dn, so, co, ov);
      chk({tag, " done_single"}, 32'(dn), 32'd0);
      chk({tag, " start_in_done_refused"}, 32'(bz), 32'd0);
      chk({tag, " So_hold"}, 32'(so), 32'(eso));
   endtask

   initial begin
      logic bz, dn, co, ov;
      logic [15:0] so;
      int ndone;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         sample(w[0], bz, dn, so, co, ov);
         chk("reset busy", 32'(bz), 32'd0);
         chk("reset done", 32'(dn), 32'd0);
         chk("reset So", 32'(so), 32'd0);
         chk("reset Co", 32'(co), 32'd0);
         chk("reset ovf", 32'(ov), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // 8-bit, STEP=1
      do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w8 ff+01");
      do_op(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0, "w8 05-07");
      do_op(1'b0, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1, "w8 80-01");
      do_op(1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, "w8 7f+01");
      do_op(1'b0, 16'h0040, 16'h003F, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, "w8 40+3f+1");
      do_op(1'b0, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b1, 16'h0046, 1'b0, 1'b0, "w8 inj 12+34");

      // reset in the 4th RUN cycle aborts the operation
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0011, 16'h0022, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      sample(1'b0, bz, dn, so, co, ov);
      chk("abort busy", 32'(bz), 32'd0);
      chk("abort done", 32'(dn), 32'd0);
      chk("abort So", 32'(so), 32'd0);
      chk("abort Co", 32'(co), 32'd0);
      chk("abort ovf", 32'(ov), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         ndone += int'(bus8.done);
      end
      chk("abort no_done", ndone, 0);
      do_op(1'b0, 16'h000F, 16'h00F0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w8 after_abort");

      // 16-bit, STEP=4
      do_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "w16 1234+4321");
      do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w16 ffff+0001");
      do_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "w16 7fff+0001");
      do_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "w16 8000-0001");
      do_op(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, "w16 0005-0007");
      do_op(1'b1, 16'h1000, 16'h1000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "w16 1000-1000");
      do_op(1'b1, 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, "w16 0003-0001");
      do_op(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0, "w16 inj abcd+1111+1");
      do_op(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "w16 8000+8000");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
